// File: rtl/llfifo_rr_drain.sv
// llfifo_rr_drain
// Round-robin drain stage for the shared-memory linked-list FIFO. It picks one
// eligible (non-empty and enabled) FIFO per cycle, pops it, captures the
// FIFO's combinational read data in the same cycle, and presents the word,
// tagged with its source index, on a registered valid/ready port backed by a
// 2-entry buffer. No pop is issued while the upstream writer is pushing.
//
// Ports:
//   clk        - clock, rising edge
//   rst_n      - asynchronous active-low reset
//   empty      - per-FIFO empty flags (1 = no entries)
//   fifo_data  - FIFO read data, valid in the cycle pop is asserted
//   push_busy  - upstream writer is pushing this cycle
//   enable     - per-FIFO drain enable
//   pop        - zero or one-hot pop strobe to the FIFO
//   out_valid  - output buffer holds a word
//   out_ready  - consumer accepts the head word
//   out_data   - head word of the output buffer
//   out_id     - source FIFO index of out_data
module llfifo_rr_drain #(
  parameter int WIDTH     = 8,
  parameter int NUM_FIFOS = 2,
  parameter int ID_WIDTH  = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_FIFOS-1:0] empty,
  input  logic [WIDTH-1:0]     fifo_data,
  input  logic                 push_busy,
  input  logic [NUM_FIFOS-1:0] enable,
  output logic [NUM_FIFOS-1:0] pop,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [ID_WIDTH-1:0]  out_id
);

  logic [NUM_FIFOS-1:0] elig;
  logic [ID_WIDTH-1:0]  gnt;
  logic                 gnt_found;
  logic                 can_pop;
  logic                 handshake;
  int                   idx;

  logic [1:0]          count_q, count_d;
  logic                wr_ptr_q, wr_ptr_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic [ID_WIDTH-1:0] last_q, last_d;
  logic [WIDTH-1:0]    data_q [2];
  logic [ID_WIDTH-1:0] id_q [2];

  assign elig = ~empty & enable;

  // Round-robin search starting just after the last granted FIFO. The first
  // eligible index in wrap-around order wins.
  always_comb begin
    gnt       = '0;
    gnt_found = 1'b0;
    idx       = 0;
    for (int k = 1; k <= NUM_FIFOS; k++) begin
      idx = (int'(last_q) + k) % NUM_FIFOS;
      for (int j = 0; j < NUM_FIFOS; j++) begin
        if (!gnt_found && (j == idx) && elig[j]) begin
          gnt_found = 1'b1;
          gnt       = ID_WIDTH'(j);
        end
      end
    end
  end

  // Gating on the registered occupancy keeps out_ready out of the pop path;
  // rst_n is included so pop drops the moment reset asserts.
  assign can_pop = rst_n & ~push_busy & (count_q < 2'd2) & gnt_found;
  assign pop     = can_pop ? (NUM_FIFOS'(1) << gnt) : '0;

  assign out_valid = (count_q != 2'd0);
  assign handshake = out_valid & out_ready;
  assign out_data  = data_q[rd_ptr_q];
  assign out_id    = id_q[rd_ptr_q];

  // Next-state for occupancy, pointers and the arbitration history.
  always_comb begin
    count_d  = count_q + {1'b0, can_pop} - {1'b0, handshake};
    wr_ptr_d = wr_ptr_q ^ can_pop;
    rd_ptr_d = rd_ptr_q ^ handshake;
    last_d   = can_pop ? gnt : last_q;
  end

  // State registers. A write only ever targets the slot not being presented
  // (count < 2 guarantees wr_ptr != rd_ptr while valid), so a stalled head
  // word never changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      last_q   <= ID_WIDTH'(NUM_FIFOS - 1);
      for (int e = 0; e < 2; e++) begin
        data_q[e] <= '0;
        id_q[e]   <= '0;
      end
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      last_q   <= last_d;
      if (can_pop) begin
        data_q[wr_ptr_q] <= fifo_data;
        id_q[wr_ptr_q]   <= gnt;
      end
    end
  end

endmodule

// File: doc/llfifo_rr_drain.md
# llfifo_rr_drain

Round-robin drain stage placed directly downstream of the shared-memory linked-list FIFO. It watches the per-FIFO `empty` flags and issues legal one-hot `pop` strobes, at most one per cycle. It captures the FIFO's combinational read data in the same cycle as the pop and presents it, tagged with its source FIFO index, on a registered valid/ready output through a 2-entry buffer. Pops are suppressed in any cycle where the upstream writer is pushing, because the linked-list FIFO cannot push and pop in the same cycle.

## Interface
Parameters:
- `WIDTH`, 8, data width; must match the FIFO's `WIDTH`.
- `NUM_FIFOS`, 2, number of FIFOs sharing the memory.
- `ID_WIDTH`, `$clog2(NUM_FIFOS)` (minimum 1), width of the source tag.

Ports:
- `clk`  in  1  single clock; all state is updated on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `empty`  in  NUM_FIFOS  FIFO empty flags; bit i = 1 means FIFO i holds no entries.
- `fifo_data`  in  WIDTH  FIFO `data_out`; valid in the same cycle `pop` is asserted.
- `push_busy`  in  1  high in any cycle the upstream writer drives a nonzero `push`.
- `enable`  in  NUM_FIFOS  per-FIFO drain enable; a FIFO with bit = 0 is never granted.
- `pop`  out  NUM_FIFOS  zero or one-hot pop strobe to the FIFO.
- `out_valid`  out  1  output holds a word.
- `out_ready`  in  1  consumer accepts a word.
- `out_data`  out  WIDTH  head word of the output buffer.
- `out_id`  out  ID_WIDTH  source FIFO index of `out_data`.

## Operation
- **Eligibility.** `elig[i] = ~empty[i] & enable[i]`.
- **Issue condition.** `can_pop = rst_n & ~push_busy & (count < 2) & |elig`.
  - `count` is the registered output-buffer occupancy (0..2).
  - Gating on the registered `count` keeps `out_ready` out of the `pop` combinational path.
- **Round-robin arbitration.**
  - Register `last` (ID_WIDTH bits) is reset to NUM_FIFOS-1.
  - Search order is `last+1, last+2, …`, wrapping modulo NUM_FIFOS. The first eligible index wins and becomes `gnt`.
  - `pop = can_pop ? onehot(gnt) : 0`. `pop` is combinational and is never multi-hot.
  - On a pop, `last <= gnt`. Without a pop, `last` holds.
- **Capture.** On a pop, `{gnt, fifo_data}` is written into the buffer at `wr_ptr`.
- **Output buffer.**
  - Two entries, with 1-bit `wr_ptr` and `rd_ptr`.
  - `out_valid = (count != 0)`. `out_data`/`out_id` come from the entry at `rd_ptr`, which is a flop output.
  - A handshake is `out_valid & out_ready`; it advances `rd_ptr`.
  - Next `count = count + pop_any - handshake`. A pop and a handshake in the same cycle leave `count` unchanged.
  - Buffer entries are stable while `out_valid & ~out_ready`. Data must not change while valid and stalled.
- **Reset.** Asynchronously clears `count`, both pointers, all entries, and `last <= NUM_FIFOS-1`.
  - Reset values: `out_valid`=0, `out_data`=0, `out_id`=0.
  - `pop`=0 whenever `rst_n`=0, including mid-operation.
  - Words held in the buffer when reset asserts are discarded.
- **Disallowed input.** `empty` bits for disabled FIFOs are don't-care.

## Timing
- **Latency.** A pop in cycle N makes the word visible on `out_*` in cycle N+1, when the buffer was empty.
- **Throughput.** One word per cycle sustained while `out_ready`=1, `push_busy`=0 and some FIFO is eligible.
  - Steady state is `count`=1.
- **Stall.** With `out_ready` low, at most 2 pops are issued; then `pop` stays 0.
  - The cycle after the first handshake, `count`=1 and pops resume.
- **Empty-flag update.** `empty` is used in the same cycle it is sampled.
  - The FIFO updates `empty` at the edge that completes a pop, so back-to-back pops of a single-entry FIFO cannot occur.
- **Simultaneous events.** `push_busy` and eligibility in the same cycle: no pop, and `last` is unchanged.
  - A handshake with no pop: `count` decrements.
- **Pointer wrap.** Buffer pointers wrap 1→0. `last` wraps NUM_FIFOS-1→0.

## Test plan
- **Reset.** Assert `rst_n`=0 mid-stream with `count`=2 and `empty`=2'b00.
  - → `pop`=0 and `out_valid`=0 immediately (asynchronously), `out_data`=0, `out_id`=0.
  - After release, the first grant is FIFO 0.
- **Round-robin.** Both FIFOs hold 3 words (A0..A2, B0..B2); `out_ready`=1 throughout.
  - → `out_id` sequence 0,1,0,1,0,1; data A0,B0,A1,B1,A2,B2.
  - One word per cycle after 1-cycle latency; `pop` is never 2'b11.
- **Backpressure.** FIFO 0 holds 5 words; `out_ready`=0 for 6 cycles, then 1.
  - → exactly 2 pops, `out_data` held at word0 throughout the stall.
  - Then words 0..4 arrive in order with no gaps after the first handshake.
- **Push collision.** FIFO 1 is non-empty; `push_busy`=1 for 3 cycles.
  - → `pop`=0 for those 3 cycles, and `last` does not change.
  - The pop of FIFO 1 occurs in the first cycle `push_busy`=0.
- **Enable mask.** `enable`=2'b10, both FIFOs non-empty.
  - → only FIFO 1 is drained until it is empty.
  - Setting `enable`=2'b11 then resumes FIFO 0.
- **Single-entry drain.** FIFO 0 holds 1 word; `empty` toggles to 1 after the pop.
  - → exactly one pop pulse, one output word with `out_id`=0, and no further pops.
